ring_dec: RTL and testbench

Receive-side decoder and checker for the one-hot ring-counter code (0001→0010→0100→1000→0001 for N=4). It samples a ring-code bus and converts each one-hot word to a binary index. It locks onto a correctly rotating sequence, then flags and counts sequence errors. It sits at the far end of a ring-counter link and gives downstream logic a checked position, a wrap pulse and link health.

---
 rtl/ring_dec.sv | 123 ++++++++++++
 tb/tb_ring_dec.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_dec.sv
// rtl/ring_dec.sv - one-hot ring-code decoder with sequence lock, flywheel and error count
module ring_dec #(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int MISS_MAX = 2,
    parameter  int ERR_W    = 8,
    localparam int IW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     d_in,
    input  logic             clr,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             wrap,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    localparam logic [IW-1:0]    TOP     = IW'(N - 1);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       MISS_C  = 4'(MISS_MAX);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] pos;
    logic [IW-1:0] nxt;
    logic [3:0]    match;
    logic [3:0]    miss;
    logic          one_hot;
    logic          in_seq;
    logic          bad_smp;

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (d_in[i]) pos = IW'(i);
        end
        one_hot = (d_in != '0) && ((d_in & (d_in - N'(1))) == '0);
        nxt     = (last == TOP) ? '0 : last + 1'b1;
        in_seq  = one_hot && (pos == nxt);
        bad_smp = en && (state == LOCK) && !in_seq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            last    <= '0;
            match   <= '0;
            miss    <= '0;
            idx     <= '0;
            idx_vld <= 1'b0;
            wrap    <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            idx_vld <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;

            // clear has priority over a coincident error
            if (clr)
                err_cnt <= '0;
            else if (bad_smp && err_cnt != CNT_MAX)
                err_cnt <= err_cnt + 1'b1;

            if (en) begin
                case (state)
                    HUNT: begin
                        if (one_hot) begin
                            last  <= pos;
                            match <= '0;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!one_hot) begin
                            state <= HUNT;
                        end else begin
                            last <= pos;
                            if (pos == nxt) begin
                                match <= match + 4'd1;
                                if (match + 4'd1 == LOCK_C) begin
                                    state  <= LOCK;
                                    miss   <= '0;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match <= '0;
                            end
                        end
                    end
                    LOCK: begin
                        if (in_seq) begin
                            last    <= pos;
                            idx     <= pos;
                            idx_vld <= 1'b1;
                            wrap    <= (last == TOP);
                            miss    <= '0;
                        end else begin
                            // flywheel: advance the expected position without trusting the word
                            err  <= 1'b1;
                            last <= nxt;
                            miss <= miss + 4'd1;
                            if (miss + 4'd1 == MISS_C) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_dec.sv
// tb/tb_ring_dec.sv - randomized and directed check of ring_dec against a behavioural model
module tb_ring_dec;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] d_in;
    logic       clr;

    logic [1:0] idx0, idx1;
    logic       vld0, vld1, wrap0, wrap1, lock0, lock1, err0, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // model state, one slot per instance
    int md[2], lst[2], run[2], mis[2];
    int e_idx[2], e_vld[2], e_wrap[2], e_lock[2], e_err[2], e_cnt[2];
    int p_lock[2] = '{3, 3};
    int p_miss[2] = '{2, 15};
    int p_cmax[2] = '{255, 3};

    ring_dec #(.N(4), .LOCK_CNT(3), .MISS_MAX(2), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .d_in(d_in), .clr(clr),
        .idx(idx0), .idx_vld(vld0), .wrap(wrap0), .locked(lock0), .err(err0), .err_cnt(cnt0)
    );

    ring_dec #(.N(4), .LOCK_CNT(3), .MISS_MAX(15), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .d_in(d_in), .clr(clr),
        .idx(idx1), .idx_vld(vld1), .wrap(wrap1), .locked(lock1), .err(err1), .err_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md[i] = 0; lst[i] = 0; run[i] = 0; mis[i] = 0;
            e_idx[i] = 0; e_vld[i] = 0; e_wrap[i] = 0;
            e_lock[i] = 0; e_err[i] = 0; e_cnt[i] = 0;
        end
    endtask

    // mode: 0 hunting, 1 verifying rotation, 2 locked
    task automatic model_step(input logic e, input logic [3:0] d, input logic c);
        int ones, p, nx;
        if (rst) begin
            model_reset();
            return;
        end
        ones = 0; p = 0;
        for (int b = 0; b < 4; b++) if (d[b]) begin ones++; p = b; end
        for (int i = 0; i < 2; i++) begin
            e_vld[i] = 0; e_wrap[i] = 0; e_err[i] = 0;
            nx = (lst[i] + 1) % 4;
            if (e) begin
                if (md[i] == 0) begin
                    if (ones == 1) begin lst[i] = p; run[i] = 0; md[i] = 1; end
                end else if (md[i] == 1) begin
                    if (ones != 1) md[i] = 0;
                    else if (p == nx) begin
                        lst[i] = p; run[i]++;
                        if (run[i] == p_lock[i]) begin md[i] = 2; mis[i] = 0; end
                    end else begin
                        lst[i] = p; run[i] = 0;
                    end
                end else begin
                    if (ones == 1 && p == nx) begin
                        e_wrap[i] = (lst[i] == 3);
                        lst[i] = p; e_idx[i] = p; e_vld[i] = 1; mis[i] = 0;
                    end else begin
                        e_err[i] = 1; lst[i] = nx; mis[i]++;
                        if (mis[i] == p_miss[i]) md[i] = 0;
                    end
                end
            end
            if (c) e_cnt[i] = 0;
            else if (e_err[i] && e_cnt[i] < p_cmax[i]) e_cnt[i]++;
            e_lock[i] = (md[i] == 2);
        end
    endtask

    task automatic cyc(input logic e, input logic [3:0] d, input logic c);
        en = e; d_in = d; clr = c;
        @(posedge clk);
        model_step(e, d, c);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("idx0", idx0, e_idx[0]);   chk("idx1", idx1, e_idx[1]);
            chk("vld0", vld0, e_vld[0]);   chk("vld1", vld1, e_vld[1]);
            chk("wrap0", wrap0, e_wrap[0]); chk("wrap1", wrap1, e_wrap[1]);
            chk("lock0", lock0, e_lock[0]); chk("lock1", lock1, e_lock[1]);
            chk("err0", err0, e_err[0]);   chk("err1", err1, e_err[1]);
            chk("cnt0", cnt0, e_cnt[0]);   chk("cnt1", cnt1, e_cnt[1]);
        end
    end

    initial begin
        int rot;
        logic e, c;
        logic [3:0] d;
        rst = 1'b1; en = 1'b0; d_in = 4'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idx", idx0, 0); chk("rst_lock", lock0, 0);
        chk("rst_cnt", cnt0, 0); chk("rst_vld", vld0, 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // acquire lock, then wrap
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b0100, 0);
        chk("lock_early", lock0, 0);
        cyc(1, 4'b1000, 0);
        chk("lock_4th", lock0, 1); chk("no_vld_on_lock", vld0, 0);
        cyc(1, 4'b0001, 0);
        chk("first_idx", idx0, 0); chk("first_vld", vld0, 1); chk("first_wrap", wrap0, 1);
        cyc(1, 4'b0010, 0);
        chk("idx1_lit", idx0, 1); chk("wrap_off", wrap0, 0);

        // single dropout is flywheeled
        cyc(1, 4'b0000, 0);
        chk("drop_err", err0, 1); chk("drop_cnt", cnt0, 1); chk("drop_lock", lock0, 1);
        cyc(1, 4'b1000, 0);
        chk("resume_idx", idx0, 3); chk("resume_vld", vld0, 1);
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b0100, 0);
        chk("hold_idx", idx0, 2);

        // enable low with garbage input
        for (int k = 0; k < 5; k++) begin
            cyc(0, 4'($urandom_range(0, 15)), 0);
            chk("hold_vld", vld0, 0); chk("hold_err", err0, 0);
        end
        cyc(1, 4'b1000, 0);
        chk("after_hold_idx", idx0, 3); chk("after_hold_vld", vld0, 1);

        // two bad words drop lock; wide miss window keeps second instance locked
        cyc(1, 4'b0110, 0); cyc(1, 4'b0110, 0);
        chk("lost_lock", lock0, 0); chk("lost_cnt", cnt0, 3);
        chk("sat_cnt", cnt1, 3); chk("wide_lock", lock1, 1);
        cyc(1, 4'b0110, 1);
        chk("clr_err", err1, 1); chk("clr_wins", cnt1, 0); chk("clr_cnt0", cnt0, 0);

        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b0100, 0);
        chk("relock_early", lock0, 0);
        cyc(1, 4'b1000, 0);
        chk("relock", lock0, 1);
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b0100, 0); cyc(1, 4'b1000, 0);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("async_idx", idx0, 0); chk("async_lock", lock0, 0); chk("async_vld", vld0, 0);
        @(posedge clk);
        model_step(en, d_in, clr);
        #1 rst = 1'b0;

        // out-of-sequence word restarts verification
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b1000, 0);
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0);
        chk("restart_nolock", lock0, 0);
        cyc(1, 4'b0100, 0);
        chk("restart_lock", lock0, 1);

        rot = 3;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                #3 rst = 1'b1;
                model_reset();
                @(posedge clk);
                model_step(en, d_in, clr);
                #1 rst = 1'b0;
            end
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 8) d = 4'(1 << rot);
            else d = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 63) == 0);
            cyc(e, d, c);
            if (e) rot = (rot + 1) % 4;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
